// File: rtl/note_envelope_if.sv
// +----------------------------------------------------------------------------+
// | note_envelope_if                                                           |
// | Bus bundle between the divider/sample sources, note_envelope, note_gen and |
// | speaker_control.                                                           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface note_envelope_if;
  logic               en;
  logic        [21:0] note_div_left_in;
  logic        [21:0] note_div_right_in;
  logic signed [15:0] audio_in_left;
  logic signed [15:0] audio_in_right;
  logic        [21:0] note_div_left_out;
  logic        [21:0] note_div_right_out;
  logic signed [15:0] audio_out_left;
  logic signed [15:0] audio_out_right;
  logic         [7:0] env_level;
  logic               busy;

  modport master (
    output en, note_div_left_in, note_div_right_in, audio_in_left, audio_in_right,
    input  note_div_left_out, note_div_right_out, audio_out_left, audio_out_right,
    input  env_level, busy
  );

  modport slave (
    input  en, note_div_left_in, note_div_right_in, audio_in_left, audio_in_right,
    output note_div_left_out, note_div_right_out, audio_out_left, audio_out_right,
    output env_level, busy
  );
endinterface

`default_nettype wire

// File: rtl/note_envelope.sv
// +----------------------------------------------------------------------------+
// | note_envelope                                                              |
// | Attack/sustain/release gain envelope with divider hold for the tone path.  |
// | Optional: NOTE_ENVELOPE_EXP_RELEASE_EN selects an exponential release.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module note_envelope #(
  parameter int TICK_DIV    = 50000,
  parameter int ATK_STEP    = 16,
  parameter int REL_STEP    = 4,
  parameter int SILENCE_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  note_envelope_if.slave   bus
);

  localparam int          CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [21:0] c_silence = 22'(SILENCE_DIV);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ATTACK  = 2'd1,
    S_SUSTAIN = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t             r_state;
  logic         [7:0] r_gain;
  logic               r_busy;
  logic [CNT_W-1:0]   r_tick_cnt;
  logic        [21:0] r_prev_l;
  logic        [21:0] r_prev_r;
  logic        [21:0] r_div_l;
  logic        [21:0] r_div_r;
  logic signed [15:0] r_audio_l;
  logic signed [15:0] r_audio_r;

  logic               w_tick;
  logic               w_sounding;
  logic               w_onset;
  logic         [8:0] w_atk_sum;
  logic         [7:0] w_gain_up;
  logic         [7:0] w_gain_dn;
  logic signed [23:0] w_prod_l;
  logic signed [23:0] w_prod_r;

  assign w_tick     = (r_tick_cnt == CNT_W'(TICK_DIV - 1));
  assign w_sounding = bus.en && ((bus.note_div_left_in  != c_silence) ||
                                 (bus.note_div_right_in != c_silence));
  assign w_onset    = w_sounding && ((bus.note_div_left_in  != r_prev_l) ||
                                     (bus.note_div_right_in != r_prev_r));

  assign w_atk_sum  = {1'b0, r_gain} + 9'(ATK_STEP);
  assign w_gain_up  = (w_atk_sum > 9'd255) ? 8'd255 : w_atk_sum[7:0];

`ifdef NOTE_ENVELOPE_EXP_RELEASE_EN
  logic [7:0] w_decay;
  // Decay proportional to G, plus one so the tail always reaches zero.
  assign w_decay    = {3'b000, r_gain[7:3]} + 8'd1;
  assign w_gain_dn  = (r_gain >= w_decay) ? (r_gain - w_decay) : 8'd0;
`else
  assign w_gain_dn  = (r_gain >= 8'(REL_STEP)) ? (r_gain - 8'(REL_STEP)) : 8'd0;
`endif

  // Sign-extended sample times zero-extended gain; the product fits 24 bits signed.
  assign w_prod_l   = $signed({{8{bus.audio_in_left[15]}},  bus.audio_in_left})  *
                      $signed({16'd0, r_gain});
  assign w_prod_r   = $signed({{8{bus.audio_in_right[15]}}, bus.audio_in_right}) *
                      $signed({16'd0, r_gain});

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_gain     <= 8'd0;
      r_busy     <= 1'b0;
      r_tick_cnt <= '0;
      r_prev_l   <= c_silence;
      r_prev_r   <= c_silence;
      r_div_l    <= c_silence;
      r_div_r    <= c_silence;
      r_audio_l  <= 16'sd0;
      r_audio_r  <= 16'sd0;
    end else begin
      r_prev_l   <= bus.note_div_left_in;
      r_prev_r   <= bus.note_div_right_in;
      r_tick_cnt <= w_tick ? '0 : (r_tick_cnt + CNT_W'(1));
      r_audio_l  <= 16'(w_prod_l >>> 8);
      r_audio_r  <= 16'(w_prod_r >>> 8);

      if (w_sounding) begin
        r_div_l <= bus.note_div_left_in;
        r_div_r <= bus.note_div_right_in;
      end

      // Any state change consumes the edge: G only steps when the state is kept.
      case (r_state)
        S_IDLE: begin
          r_gain <= 8'd0;
          if (w_onset) begin
            r_state <= S_ATTACK;
            r_busy  <= 1'b1;
          end
        end
        S_ATTACK: begin
          if (w_onset) begin
            r_state <= S_ATTACK;
          end else if (!w_sounding) begin
            r_state <= S_RELEASE;
          end else if (r_gain == 8'd255) begin
            r_state <= S_SUSTAIN;
          end else if (w_tick) begin
            r_gain <= w_gain_up;
          end
        end
        S_SUSTAIN: begin
          if (w_onset) begin
            r_state <= S_ATTACK;
          end else if (!w_sounding) begin
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (w_onset) begin
            r_state <= S_ATTACK;
          end else if (r_gain == 8'd0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (!w_sounding) begin
              r_div_l <= c_silence;
              r_div_r <= c_silence;
            end
          end else if (w_tick) begin
            r_gain <= w_gain_dn;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_gain  <= 8'd0;
        end
      endcase
    end
  end

  assign bus.note_div_left_out  = r_div_l;
  assign bus.note_div_right_out = r_div_r;
  assign bus.audio_out_left     = r_audio_l;
  assign bus.audio_out_right    = r_audio_r;
  assign bus.env_level          = r_gain;
  assign bus.busy               = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_note_envelope.sv
// +----------------------------------------------------------------------------+
// | tb_note_envelope                                                           |
// | Directed self-checking bench for note_envelope with TICK_DIV=4.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_note_envelope;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  note_envelope_if ifc ();

  note_envelope #(
    .TICK_DIV    (4),
    .ATK_STEP    (16),
    .REL_STEP    (4),
    .SILENCE_DIV (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int atk_next(input int g);
    return (g + 16 > 255) ? 255 : g + 16;
  endfunction

  function automatic int rel_next(input int g);
`ifdef NOTE_ENVELOPE_EXP_RELEASE_EN
    int d;
    d = (g >> 3) + 1;
    return (g >= d) ? g - d : 0;
`else
    return (g >= 4) ? g - 4 : 0;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next gain change and checks value and tick spacing.
  task automatic wait_step(input string tag, input int exp, input bit gap);
    int         n;
    logic [7:0] start;
    n     = 0;
    start = ifc.env_level;
    while ((ifc.env_level === start) && (n < 40)) begin
      step(1);
      n++;
    end
    chk(tag, ifc.env_level, exp);
    if (gap) chk({tag, "_gap"}, n, 4);
  endtask

  initial begin
    int g;
    int prev_g;
    checks   = 0;
    failures = 0;

    rst                   = 1'b0;
    ifc.en                = 1'b0;
    ifc.note_div_left_in  = 22'd1;
    ifc.note_div_right_in = 22'd1;
    ifc.audio_in_left     = 16'sd0;
    ifc.audio_in_right    = 16'sd0;
    step(2);
    rst = 1'b1;
    step(1);
    chk("rst_env",   ifc.env_level, 0);
    chk("rst_busy",  ifc.busy, 0);
    chk("rst_divl",  ifc.note_div_left_out, 1);
    chk("rst_divr",  ifc.note_div_right_out, 1);
    chk("rst_audl",  ifc.audio_out_left, 0);
    chk("rst_audr",  ifc.audio_out_right, 0);

    // Note on from silence
    ifc.en               = 1'b1;
    ifc.note_div_left_in = 22'd262;
    step(1);
    chk("on_busy", ifc.busy, 1);
    chk("on_env",  ifc.env_level, 0);
    chk("on_divl", ifc.note_div_left_out, 262);
    chk("on_divr", ifc.note_div_right_out, 1);
    g = 0;
    for (int k = 0; k < 16; k++) begin
      g = atk_next(g);
      wait_step("atk", g, k > 0);
    end
    step(13);
    chk("sus_env",  ifc.env_level, 255);
    chk("sus_busy", ifc.busy, 1);

    // Audio scaling at G=255
    ifc.audio_in_left  = 16'sd16384;
    ifc.audio_in_right = -16'sd200;
    step(1);
    chk("aud_pos_l", ifc.audio_out_left, 16320);
    chk("aud_neg_r", ifc.audio_out_right, -200);
    ifc.audio_in_left  = -16'sd16384;
    ifc.audio_in_right = 16'sd200;
    step(1);
    chk("aud_neg_l", ifc.audio_out_left, -16320);
    chk("aud_pos_r", ifc.audio_out_right, 199);
    ifc.audio_in_left = -16'sd1;
    step(1);
    chk("aud_m1", ifc.audio_out_left, -1);
    ifc.audio_in_left = 16'sd1;
    step(1);
    chk("aud_p1", ifc.audio_out_left, 0);
    ifc.audio_in_left  = 16'sd0;
    ifc.audio_in_right = 16'sd0;

    // Full release to idle
    ifc.en = 1'b0;
    step(1);
    chk("rel_busy", ifc.busy, 1);
    chk("rel_env",  ifc.env_level, 255);
    chk("rel_divl", ifc.note_div_left_out, 262);
    g = 255;
    for (int k = 0; k < 80 && g > 0; k++) begin
      g = rel_next(g);
      wait_step("rel", g, k > 0);
    end
    chk("rel0_busy", ifc.busy, 1);
    chk("rel0_divl", ifc.note_div_left_out, 262);
    step(1);
    chk("idle_busy", ifc.busy, 0);
    chk("idle_divl", ifc.note_div_left_out, 1);
    chk("idle_divr", ifc.note_div_right_out, 1);
    chk("idle_env",  ifc.env_level, 0);

    // Second note, early stop, retrigger during release
    ifc.en               = 1'b1;
    ifc.note_div_left_in = 22'd330;
    step(1);
    chk("on2_busy", ifc.busy, 1);
    g = 0;
    for (int k = 0; k < 7; k++) begin
      g = atk_next(g);
      wait_step("atk2", g, k > 0);
    end
    ifc.en = 1'b0;
    step(1);
    chk("stop_nostep", ifc.env_level, g);
    for (int k = 0; k < 3; k++) begin
      g = rel_next(g);
      wait_step("rel2", g, k > 0);
    end
    ifc.en               = 1'b1;
    ifc.note_div_left_in = 22'd294;
    step(1);
    chk("retrig_nostep", ifc.env_level, g);
    chk("retrig_divl",   ifc.note_div_left_out, 294);
    for (int k = 0; k < 2; k++) begin
      g = atk_next(g);
      wait_step("retrig_atk", g, k > 0);
    end

    // en falling with a divider change is a stop, not an onset
    ifc.en               = 1'b0;
    ifc.note_div_left_in = 22'd330;
    step(1);
    chk("enfall_nostep", ifc.env_level, g);
    chk("enfall_divl",   ifc.note_div_left_out, 294);
    g = rel_next(g);
    wait_step("enfall_rel", g, 1'b0);
    chk("enfall_divl2", ifc.note_div_left_out, 294);

    // Retrigger, then reset mid-attack
    ifc.en               = 1'b1;
    ifc.note_div_left_in = 22'd262;
    ifc.audio_in_left    = 16'sd16384;
    step(1);
    prev_g = g;
    g      = atk_next(g);
    wait_step("atk3", g, 1'b0);
    chk("aud_prevg", ifc.audio_out_left, 64 * prev_g);
    rst = 1'b0;
    step(1);
    chk("mrst_env",  ifc.env_level, 0);
    chk("mrst_busy", ifc.busy, 0);
    chk("mrst_divl", ifc.note_div_left_out, 1);
    chk("mrst_divr", ifc.note_div_right_out, 1);
    chk("mrst_audl", ifc.audio_out_left, 0);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/note_envelope.md
Name: note_envelope

Overview:
- Attack/sustain/release amplitude envelope for the tone path.
- Upstream of note_gen: takes the raw per-channel dividers from the octave/frequency stage and passes on held dividers, so a note keeps sounding through its release.
- Downstream of note_gen: scales its square-wave samples by an 8-bit envelope gain before they go to speaker_control.
- Removes clicks on note start, note stop and pause.

Parameters:
- TICK_DIV, 50000: clk cycles per envelope tick (1 ms at 50 MHz).
- ATK_STEP, 16: gain increment per tick in ATTACK.
- REL_STEP, 4: gain decrement per tick in RELEASE.
- SILENCE_DIV, 1: divider value meaning "no note".

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  play/pause level; 1 = playing.
- note_div_left_in  in  22  raw left divider.
- note_div_right_in  in  22  raw right divider.
- audio_in_left  in  16  signed left sample from note_gen.
- audio_in_right  in  16  signed right sample from note_gen.
- note_div_left_out  out  22  held left divider to note_gen.
- note_div_right_out  out  22  held right divider to note_gen.
- audio_out_left  out  16  signed enveloped left sample to speaker_control.
- audio_out_right  out  16  signed enveloped right sample to speaker_control.
- env_level  out  8  current gain G.
- busy  out  1  1 when state != IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst==0 at a clk edge):
  - state = IDLE, G = 0, tick counter = 0.
  - prev_div registers = SILENCE_DIV, both div outputs = SILENCE_DIV.
  - audio outputs = 0, busy = 0.
- Tick: free-running counter 0..TICK_DIV-1; tick=1 on the cycle the counter equals TICK_DIV-1. The counter is not cleared by note events.
- sounding = en && (left_in != SILENCE_DIV || right_in != SILENCE_DIV).
- onset = sounding && (left_in != prev_left || right_in != prev_right). prev_* register the inputs every cycle.
- States:
  - IDLE: G held at 0. onset -> ATTACK.
  - ATTACK: on tick, G = min(G + ATK_STEP, 255). At 255 -> SUSTAIN.
  - SUSTAIN: G held.
  - RELEASE: on tick, G = max(G - REL_STEP, 0). At 0 -> IDLE.
- Stop: !sounding in ATTACK or SUSTAIN -> RELEASE.
- Retrigger: onset in ATTACK, SUSTAIN or RELEASE -> ATTACK, starting from the current G (no drop to 0).
- Simultaneous events:
  - On the transition cycle G does not step, even if tick=1; stepping resumes on the next tick.
  - en falling together with a divider change counts as a stop (RELEASE), never an onset.
- Divider hold:
  - While sounding, the div outputs register the inputs (1-cycle latency).
  - While !sounding, the outputs keep their last values until the IDLE entry cycle, then load SILENCE_DIV.
- Audio path:
  - out = (in * G) >>> 8, 24-bit signed product, arithmetic shift, registered.
  - Latency 1 cycle, using the G value before any update on that same edge.
  - G=0 gives 0; G=255 gives in*255/256, truncated toward negative infinity.
- Reset mid-note immediately forces the reset values; no release is played.

Optional Feature:
- Macro: NOTE_ENVELOPE_EXP_RELEASE_EN.
- When defined: each RELEASE tick sets G = G - ((G>>3) + 1), floored at 0, giving an exponential decay. REL_STEP is unused.
- When undefined: linear release with REL_STEP.
- All other behaviour is identical in both builds.

Test Plan:
- Reset low for 2 cycles, then release it -> all outputs 0; div outputs = 1; busy = 0; env_level = 0.
- TICK_DIV=4. en=1, left_in 0->262. -> ATTACK next cycle; env_level 16, 32, ... 255 after 16 ticks; state SUSTAIN.
- SUSTAIN with G=255, audio_in_left=16384 then -16384 -> audio_out_left = 16320 then -16320, each one cycle after the input.
- Drop en in SUSTAIN with left_in=262 -> note_div_left_out stays 262; G falls 4 per tick to 0 after 64 ticks; next cycle div outputs = 1, busy = 0.
- During RELEASE at G=100, change left_in 262->294 -> ATTACK; G goes 116, 132, ...; div output 294.
- Exp build, release from 255 -> G sequence 255, 223, 195, 170 ...; reaches 0 and goes IDLE. Assert rst low mid-attack -> all reset values on the next edge.
